grn_attractor_ctrl: RTL and testbench

- Control and detection stage that drives a bank of GRN node cells (dual-state tortoise/hare nodes) and consumes their state outputs.
- For each initial state it loads the network, steps it with Floyd cycle detection, and measures the attractor period.
- It then emits one result record per run.
- Sits between the host-side initial-state stream and the result stream; all node cells share its reset_nos/start_s0/start_s1 strobes.

---
 rtl/grn_attractor_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_grn_attractor_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grn_attractor_ctrl.sv
// ---------------------------------------------------------------------------
// grn_attractor_ctrl
//
// Drives a bank of dual-state GRN node cells. Each node keeps a tortoise copy
// (s0) and a hare copy (s1). For every initial state accepted from the host,
// the controller:
//   1. loads the network,
//   2. steps it with Floyd cycle detection until tortoise and hare meet,
//   3. steps the hare alone to measure the attractor period,
//   4. emits one result record.
// A per-phase step budget aborts runs that do not converge.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   init_valid/ready/data host initial-state stream (valid/ready handshake)
//   reset_nos             load strobe to all nodes (loads both copies)
//   init_state            per-node load value, node i takes bit i
//   start_s0 / start_s1   tortoise / hare step strobes
//   s0_vec / s1_vec       concatenated tortoise / hare states from the nodes
//   res_valid/ready       result stream handshake
//   res_state             attractor state (tortoise state at the meet)
//   res_steps             hare steps taken until the meet
//   res_period            attractor period
//   res_timeout           run aborted on the step budget
//   busy                  high whenever a run is in progress
// ---------------------------------------------------------------------------
module grn_attractor_ctrl #(
    parameter int N_NODES   = 8,
    parameter int CNT_W     = 16,
    parameter int MAX_STEPS = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               init_valid,
    output logic               init_ready,
    input  logic [N_NODES-1:0] init_data,
    output logic               reset_nos,
    output logic [N_NODES-1:0] init_state,
    output logic               start_s0,
    output logic               start_s1,
    input  logic [N_NODES-1:0] s0_vec,
    input  logic [N_NODES-1:0] s1_vec,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [N_NODES-1:0] res_state,
    output logic [CNT_W-1:0]   res_steps,
    output logic [CNT_W-1:0]   res_period,
    output logic               res_timeout,
    output logic               busy
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_STEPS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STEP,
        S_CMP,
        S_PSTEP,
        S_PCMP,
        S_OUT
    } state_t;

    state_t             state_q, state_d;
    logic [N_NODES-1:0] init_state_q, init_state_d;
    logic [CNT_W-1:0]   step_q, step_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic [N_NODES-1:0] res_state_q, res_state_d;
    logic [CNT_W-1:0]   res_steps_q, res_steps_d;
    logic [CNT_W-1:0]   res_period_q, res_period_d;
    logic               res_timeout_q, res_timeout_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            init_state_q  <= '0;
            step_q        <= '0;
            period_q      <= '0;
            res_state_q   <= '0;
            res_steps_q   <= '0;
            res_period_q  <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            init_state_q  <= init_state_d;
            step_q        <= step_d;
            period_q      <= period_d;
            res_state_q   <= res_state_d;
            res_steps_q   <= res_steps_d;
            res_period_q  <= res_period_d;
            res_timeout_q <= res_timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        init_state_d  = init_state_q;
        step_d        = step_q;
        period_d      = period_q;
        res_state_d   = res_state_q;
        res_steps_d   = res_steps_q;
        res_period_d  = res_period_q;
        res_timeout_d = res_timeout_q;

        case (state_q)
            S_IDLE: begin
                if (init_valid) begin
                    init_state_d = init_data;
                    state_d      = S_LOAD;
                end
            end
            S_LOAD: begin
                step_d        = '0;
                period_d      = '0;
                res_timeout_d = 1'b0;
                state_d       = S_STEP;
            end
            S_STEP: begin
                step_d  = step_q + 1'b1;
                state_d = S_CMP;
            end
            S_CMP: begin
                // After an odd step the tortoise and hare have both moved
                // once, so equality there says nothing about a cycle.
                if (!step_q[0] && (s0_vec == s1_vec)) begin
                    res_state_d = s0_vec;
                    res_steps_d = step_q;
                    state_d     = S_PSTEP;
                end else if (step_q == MAX_CNT) begin
                    res_timeout_d = 1'b1;
                    res_period_d  = '0;
                    res_state_d   = s1_vec;
                    res_steps_d   = step_q;
                    state_d       = S_OUT;
                end else begin
                    state_d = S_STEP;
                end
            end
            S_PSTEP: begin
                period_d = period_q + 1'b1;
                state_d  = S_PCMP;
            end
            S_PCMP: begin
                // The tortoise sits still on the attractor; the hare laps it.
                if (s1_vec == s0_vec) begin
                    res_period_d = period_q;
                    state_d      = S_OUT;
                end else if (period_q == MAX_CNT) begin
                    res_timeout_d = 1'b1;
                    res_period_d  = period_q;
                    state_d       = S_OUT;
                end else begin
                    state_d = S_PSTEP;
                end
            end
            S_OUT: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Strobes decode straight from the state register so a reset drops them
    // on the same edge that returns the FSM to IDLE.
    assign init_ready  = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign reset_nos   = (state_q == S_LOAD);
    assign start_s0    = (state_q == S_STEP);
    assign start_s1    = (state_q == S_STEP) || (state_q == S_PSTEP);
    assign res_valid   = (state_q == S_OUT);
    assign init_state  = init_state_q;
    assign res_state   = res_state_q;
    assign res_steps   = res_steps_q;
    assign res_period  = res_period_q;
    assign res_timeout = res_timeout_q;

endmodule

// File: tb/tb_grn_attractor_ctrl.sv
// ---------------------------------------------------------------------------
// tb_grn_attractor_ctrl
//
// Two controllers share a clock and reset: dut_a uses the default step budget
// and runs the main scenarios; dut_b uses a budget of 4 to reach timeouts.
// Each controller drives a behavioural node bank (tortoise armed on load,
// moving on odd tortoise strobes; hare moving on every hare strobe). The
// network function is selected by mode: 0 hold, 1 rotate low 3 bits,
// 2 increment. Expected records come from a reference Floyd walk pushed on
// acceptance and popped on each result transfer.
// ---------------------------------------------------------------------------
module tb_grn_attractor_ctrl;

    localparam int N    = 8;
    localparam int W    = 16;
    localparam int MAXA = 1000;
    localparam int MAXB = 4;

    typedef struct packed {
        logic [N-1:0] st;
        logic [W-1:0] steps;
        logic [W-1:0] period;
        logic         to;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] net_f(input int m, input logic [N-1:0] v);
        case (m)
            1:       return {v[7:3], v[1:0], v[2]};
            2:       return v + 8'd1;
            default: return v;
        endcase
    endfunction

    function automatic rec_t ref_run(input int m, input logic [N-1:0] init, input int max_steps);
        rec_t r;
        logic [N-1:0] t, h;
        int step, p;
        bit done;
        r = '0; t = init; h = init; step = 0; done = 0;
        while (!done) begin
            step++;
            h = net_f(m, h);
            if (step % 2 == 1) t = net_f(m, t);
            if ((step % 2 == 0) && (t == h)) begin
                r.st = t; r.steps = W'(step); done = 1;
            end else if (step == max_steps) begin
                r.to = 1'b1; r.st = h; r.steps = W'(step); r.period = '0;
                return r;
            end
        end
        p = 0; done = 0;
        while (!done) begin
            p++;
            h = net_f(m, h);
            if (h == t) begin
                r.period = W'(p); done = 1;
            end else if (p == max_steps) begin
                r.to = 1'b1; r.period = W'(p); done = 1;
            end
        end
        return r;
    endfunction

    // ---------------- dut_a ----------------
    logic         a_init_valid = 1'b0, a_res_ready = 1'b1;
    logic [N-1:0] a_init_data = '0;
    logic         a_init_ready, a_reset_nos, a_start_s0, a_start_s1;
    logic         a_res_valid, a_res_timeout, a_busy;
    logic [N-1:0] a_init_state, a_res_state;
    logic [W-1:0] a_res_steps, a_res_period;
    logic [N-1:0] a_s0 = '0, a_s1 = '0;
    logic         a_arm = 1'b0;
    int           mode = 0;

    grn_attractor_ctrl #(.N_NODES(N), .CNT_W(W), .MAX_STEPS(MAXA)) dut_a (
        .clk(clk), .rst(rst),
        .init_valid(a_init_valid), .init_ready(a_init_ready), .init_data(a_init_data),
        .reset_nos(a_reset_nos), .init_state(a_init_state),
        .start_s0(a_start_s0), .start_s1(a_start_s1),
        .s0_vec(a_s0), .s1_vec(a_s1),
        .res_valid(a_res_valid), .res_ready(a_res_ready),
        .res_state(a_res_state), .res_steps(a_res_steps), .res_period(a_res_period),
        .res_timeout(a_res_timeout), .busy(a_busy)
    );

    always @(posedge clk) begin
        if (a_reset_nos) begin
            a_s0 <= a_init_state; a_s1 <= a_init_state; a_arm <= 1'b1;
        end else begin
            if (a_start_s0) begin
                if (a_arm) a_s0 <= net_f(mode, a_s0);
                a_arm <= ~a_arm;
            end
            if (a_start_s1) a_s1 <= net_f(mode, a_s1);
        end
    end

    rec_t         exp_q[$];
    rec_t         a_got, a_held, a_e;
    bit           a_first = 1;
    int           acc_cyc = 0, lat = 0, s0_cnt = 0, s1_cnt = 0, n_res = 0;
    logic [N-1:0] last_state = '0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            a_first = 1;
        end else begin
            if (a_reset_nos && (a_start_s0 || a_start_s1)) check("strobe_excl", 1, 0);
            if (a_start_s0 && !a_start_s1) check("s0_without_s1", 1, 0);
            if (a_init_valid && a_init_ready) begin
                check("accept_not_busy", a_busy, 0);
                exp_q.push_back(ref_run(mode, a_init_data, MAXA));
                acc_cyc = cyc; s0_cnt = 0; s1_cnt = 0; a_first = 1;
            end
            if (a_start_s0) s0_cnt++;
            if (a_start_s1) s1_cnt++;
            if (a_res_valid) begin
                a_got = '{a_res_state, a_res_steps, a_res_period, a_res_timeout};
                if (a_first) begin
                    lat = cyc - acc_cyc; a_held = a_got; a_first = 0;
                end else begin
                    check("res_hold", a_got, a_held);
                end
                if (a_res_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", 1, 0);
                    end else begin
                        a_e = exp_q.pop_front();
                        check("res_state", a_got.st, a_e.st);
                        check("res_steps", a_got.steps, a_e.steps);
                        check("res_period", a_got.period, a_e.period);
                        check("res_timeout", a_got.to, a_e.to);
                        check("s0_strobes", s0_cnt, a_got.steps);
                        check("s1_strobes", s1_cnt, a_got.steps + a_got.period);
                        $display("result %0d: state=%02h steps=%0d period=%0d timeout=%0b latency=%0d",
                                 n_res, a_got.st, a_got.steps, a_got.period, a_got.to, lat);
                    end
                    last_state = a_got.st;
                    n_res++;
                    a_first = 1;
                end
            end
        end
    end

    // ---------------- dut_b (small step budget, incrementer network) ----------------
    logic         b_init_valid = 1'b0, b_res_ready = 1'b1;
    logic [N-1:0] b_init_data = '0;
    logic         b_init_ready, b_reset_nos, b_start_s0, b_start_s1;
    logic         b_res_valid, b_res_timeout, b_busy;
    logic [N-1:0] b_init_state, b_res_state;
    logic [W-1:0] b_res_steps, b_res_period;
    logic [N-1:0] b_s0 = '0, b_s1 = '0;
    logic         b_arm = 1'b0;

    grn_attractor_ctrl #(.N_NODES(N), .CNT_W(W), .MAX_STEPS(MAXB)) dut_b (
        .clk(clk), .rst(rst),
        .init_valid(b_init_valid), .init_ready(b_init_ready), .init_data(b_init_data),
        .reset_nos(b_reset_nos), .init_state(b_init_state),
        .start_s0(b_start_s0), .start_s1(b_start_s1),
        .s0_vec(b_s0), .s1_vec(b_s1),
        .res_valid(b_res_valid), .res_ready(b_res_ready),
        .res_state(b_res_state), .res_steps(b_res_steps), .res_period(b_res_period),
        .res_timeout(b_res_timeout), .busy(b_busy)
    );

    always @(posedge clk) begin
        if (b_reset_nos) begin
            b_s0 <= b_init_state; b_s1 <= b_init_state; b_arm <= 1'b1;
        end else begin
            if (b_start_s0) begin
                if (b_arm) b_s0 <= net_f(2, b_s0);
                b_arm <= ~b_arm;
            end
            if (b_start_s1) b_s1 <= net_f(2, b_s1);
        end
    end

    rec_t b_q[$];
    rec_t b_e;
    int   nb_res = 0;

    always @(negedge clk) begin
        if (rst) begin
            b_q.delete();
        end else begin
            if (b_init_valid && b_init_ready) b_q.push_back(ref_run(2, b_init_data, MAXB));
            if (b_res_valid && b_res_ready) begin
                if (b_q.size() == 0) begin
                    check("b_unexpected_result", 1, 0);
                end else begin
                    b_e = b_q.pop_front();
                    check("b_res_state", b_res_state, b_e.st);
                    check("b_res_steps", b_res_steps, b_e.steps);
                    check("b_res_period", b_res_period, b_e.period);
                    check("b_res_timeout", b_res_timeout, b_e.to);
                    $display("b result %0d: state=%02h steps=%0d period=%0d timeout=%0b",
                             nb_res, b_res_state, b_res_steps, b_res_period, b_res_timeout);
                end
                nb_res++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic offer_a(input logic [N-1:0] d);
        bit ok = 0;
        a_init_valid = 1'b1;
        a_init_data  = d;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (a_init_ready) begin ok = 1; break; end
        end
        if (!ok) check("accept_wait", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_results(input int target);
        for (int i = 0; i < 5000; i++) begin
            if (n_res >= target) break;
            @(negedge clk);
        end
        check("result_wait", n_res >= target, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        int base;
        bit seen;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", a_busy, 0);
        check("rst_init_ready", a_init_ready, 1);
        check("rst_res_valid", a_res_valid, 0);
        check("rst_strobes", {a_reset_nos, a_start_s0, a_start_s1}, 0);
        check("rst_init_state", a_init_state, 0);
        check("rst_res_fields", {a_res_steps, a_res_period, a_res_timeout}, 0);
        @(posedge clk); #1 rst = 1'b0;

        // Fixed point: load strobe one cycle after accept, result 8 cycles later.
        mode = 0;
        offer_a(8'hA5);
        a_init_valid = 1'b0;
        @(negedge clk);
        check("load_strobe", a_reset_nos, 1);
        check("load_value", a_init_state, 8'hA5);
        wait_results(1);
        check("fixed_latency", lat, 8);

        // Rotate of the low three bits: period 3.
        mode = 1;
        offer_a(8'h01);
        a_init_valid = 1'b0;
        wait_results(2);
        check("rot_state_on_cycle", (last_state == 8'h01) || (last_state == 8'h02) || (last_state == 8'h04), 1);

        // Incrementer: full 256-state cycle.
        mode = 2;
        offer_a(8'h00);
        a_init_valid = 1'b0;
        wait_results(3);

        // Consumer stalls in OUT while the host keeps offering.
        mode = 0;
        a_res_ready = 1'b0;
        offer_a(8'h3C);
        a_init_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (a_res_valid) begin seen = 1; break; end
        end
        check("stall_res_valid_seen", seen, 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            a_init_valid = ~a_init_valid;
            a_init_data  = 8'hFF;
            @(negedge clk);
            check("stall_init_ready", a_init_ready, 0);
            check("stall_res_valid", a_res_valid, 1);
        end
        @(posedge clk); #1;
        a_init_valid = 1'b0;
        a_res_ready  = 1'b1;
        wait_results(4);
        @(negedge clk);
        check("after_xfer_ready", a_init_ready, 1);
        check("after_xfer_valid", a_res_valid, 0);
        check("single_transfer", n_res, 4);

        // Reset during the period phase aborts the run.
        @(posedge clk); #1;
        mode = 2;
        offer_a(8'h10);
        a_init_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (a_start_s1 && !a_start_s0) begin seen = 1; break; end
        end
        check("pstep_seen", seen, 1);
        #1 rst = 1'b1;
        @(negedge clk);
        check("abort_strobes", {a_reset_nos, a_start_s0, a_start_s1}, 0);
        check("abort_busy", a_busy, 0);
        check("abort_init_ready", a_init_ready, 1);
        check("abort_res_valid", a_res_valid, 0);
        @(posedge clk); #1 rst = 1'b0;
        base = n_res;
        check("abort_no_result", base, 4);
        mode = 0;
        offer_a(8'h5A);
        a_init_valid = 1'b0;
        wait_results(base + 1);

        // init_valid held across two back-to-back runs.
        offer_a(8'h11);
        a_init_data = 8'h22;
        offer_a(8'h22);
        check("b2b_first_done_before_second", n_res, base + 2);
        a_init_valid = 1'b0;
        wait_results(base + 3);

        // Step budget exhausted on the small-budget controller.
        for (int k = 0; k < 2; k++) begin
            b_init_valid = 1'b1;
            b_init_data  = (k == 0) ? 8'h40 : 8'hFE;
            seen = 0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (b_init_ready) begin seen = 1; break; end
            end
            check("b_accept_wait", seen, 1);
            @(posedge clk); #1 b_init_valid = 1'b0;
            for (int i = 0; i < 100; i++) begin
                if (nb_res > k) break;
                @(negedge clk);
            end
            check("b_result_wait", nb_res, k + 1);
            @(posedge clk); #1;
        end

        repeat (3) @(posedge clk);
        check("a_queue_empty", exp_q.size(), 0);
        check("b_queue_empty", b_q.size(), 0);
        check("a_result_count", n_res, base + 3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete (checks=%0d errors=%0d)", checks, errors);
        $fatal(1, "global timeout");
    end

endmodule
